fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the synchronous-read instruction memory (one-cycle read latency, word addressed). It owns the PC, issues one word address per cycle, and absorbs the memory latency with a 2-entry skid FIFO. It delivers {pc, instr} to decode over a valid/ready handshake and services redirects from branch/jump resolution. It sits between the instruction memory and the IF/ID stage register.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_ctrl_if.sv | 24 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_ctrl.sv | 75 +++++++
 tb/tb_fetch_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Imported by the fetch FIFO and the fetch_ctrl top.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int          FETCH_FIFO_DEPTH = 2;

  // Fetch is word-aligned only; low byte-offset bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundles the instruction-memory port, the redirect request and the decode handshake.
// master = fetch controller side, slave = memory/decode/branch-resolution side.
interface fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 11
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_dout;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  id_ready;
  logic                  if_valid;
  logic [31:0]           if_pc;
  logic [31:0]           if_instr;

  modport master (
    output imem_addr, if_valid, if_pc, if_instr,
    input  imem_dout, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_pc, if_instr,
    output imem_dout, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Skid FIFO of {pc, instr} entries that absorbs the one-cycle memory read latency.
// Flush empties it in one cycle; push and pop in the same cycle keep count and advance the head.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    entries [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = entries[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one word read per cycle to a
// synchronous-read memory, and hands {pc, instr} to decode over valid/ready.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  fetch_ctrl_if.master  bus
);

  localparam logic [2:0] DEPTH_L = 3'(FIFO_DEPTH);

  logic [31:0]  fetch_pc;
  logic [31:0]  req_pc;
  logic         req_valid;
  logic [31:0]  addr_pc;
  logic [1:0]   count;
  logic [2:0]   occupancy;
  logic         issue;
  logic         push;
  logic         pop;
  logic         have_entry;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  // A redirect both restarts the stream and supplies this cycle's address.
  assign addr_pc       = bus.redirect_valid ? align_word(bus.redirect_pc) : fetch_pc;
  assign bus.imem_addr = addr_pc[ADDR_WIDTH+1:2];

  assign have_entry = (count != 2'd0);
  assign pop        = have_entry & bus.id_ready & ~bus.redirect_valid;
  assign push       = req_valid & ~bus.redirect_valid;
  assign push_entry = '{pc: req_pc, instr: bus.imem_dout};

  // Entries left after this cycle's pop plus the read already in flight must
  // leave room for one more, so the FIFO can never overflow.
  assign occupancy = {1'b0, count} - {2'b00, pop} + {2'b00, req_valid};
  assign issue     = bus.redirect_valid | (occupancy < DEPTH_L);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      req_valid <= 1'b0;
    end else if (issue) begin
      req_valid <= 1'b1;
      req_pc    <= addr_pc;
      fetch_pc  <= addr_pc + 32'd4;
    end else begin
      req_valid <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign bus.if_valid = have_entry;
  assign bus.if_pc    = have_entry ? head.pc    : '0;
  assign bus.if_instr = have_entry ? head.instr : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table for the timing corner cases, then
// random ready/redirect traffic checked against an instruction-stream model.
module tb_fetch_ctrl;

  localparam int AW = 11;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  fetch_ctrl_if #(.ADDR_WIDTH(AW)) bus();

  fetch_ctrl #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];

  always @(posedge clk) bus.imem_dout <= mem[bus.imem_addr];

  int          checks = 0;
  int          errors = 0;
  bit          model_en = 1'b0;
  logic [31:0] exp_pc = 32'h0;
  int          since = 0;

  typedef struct {
    bit          do_reset;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    int          eaddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit rdy, bit rv, logic [31:0] rpc,
                              bit ev, logic [31:0] epc, logic [31:0] ei, int ea);
    vec_t v;
    v.do_reset = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.einstr = ei; v.eaddr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus.id_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    since  = 0;
    exp_pc = 32'h0;
  endtask

  // Asynchronous reset while a redirect is being requested.
  task automatic mid_reset();
    @(negedge clk);
    bus.id_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0080;
    #1;
    if (since >= 2) chk("pre_reset_valid", {31'b0, bus.if_valid}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("async_rst_pc",    bus.if_pc,    32'h0);
    chk("async_rst_instr", bus.if_instr, 32'h0);
    @(negedge clk) bus.redirect_valid = 1'b0;
    @(posedge clk);
    #1 chk("held_rst_valid", {31'b0, bus.if_valid}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    since  = 0;
    exp_pc = 32'h0;
  endtask

  // One clock cycle; when the model is on, outputs are checked against the
  // expected instruction stream and the model advances on the edge.
  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc, input int eaddr);
    bit ev;
    @(negedge clk);
    bus.id_ready = rdy; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    #1;
    if (eaddr >= 0) chk("imem_addr", 32'(bus.imem_addr), eaddr[31:0]);
    if (model_en) begin
      ev = (since >= 2);
      chk("if_valid", {31'b0, bus.if_valid}, {31'b0, ev});
      if (ev) begin
        chk("if_pc",    bus.if_pc,    exp_pc);
        chk("if_instr", bus.if_instr, mem[exp_pc[AW+1:2]]);
      end else begin
        chk("idle_pc",    bus.if_pc,    32'h0);
        chk("idle_instr", bus.if_instr, 32'h0);
      end
    end
    @(posedge clk);
    if (model_en) begin
      if (rv) begin
        exp_pc = {rpc[31:2], 2'b00};
        since  = 1;
      end else begin
        if (since >= 2 && rdy) exp_pc += 32'd4;
        if (since < 2) since++;
      end
    end
  endtask

  task automatic run_table(input int lo, input int hi, input bit skip_reset);
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].do_reset && !skip_reset) apply_reset();
      @(negedge clk);
      bus.id_ready = tbl[i].rdy; bus.redirect_valid = tbl[i].rv; bus.redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("v%0d_addr", i),  32'(bus.imem_addr), tbl[i].eaddr[31:0]);
      chk($sformatf("v%0d_valid", i), {31'b0, bus.if_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("v%0d_pc", i),    bus.if_pc,    tbl[i].epc);
      chk($sformatf("v%0d_instr", i), bus.if_instr, tbl[i].einstr);
      @(posedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;

    bus.id_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = 32'h37; mem[1] = 32'h97; mem[2] = 32'h13; mem[3] = 32'hB7;

    // Startup latency and back-to-back delivery (rows 0..5)
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0, 32'h0,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0, 32'h0,  1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h0, 32'h37, 2));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h4, 32'h97, 3));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h8, 32'h13, 4));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'hC, 32'hB7, 5));
    // Stall with full FIFO, release, then redirect to a misaligned 0x43 (rows 6..20)
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0, 32'h0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 32'h0,  1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h37, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h37, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h37, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h37, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h37, 2));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h0, 32'h37, 2));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h4, 32'h97, 3));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h8, 32'h13, 4));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hC, 32'hB7, 5));
    tbl.push_back(mk(0, 1, 1, 32'h43, 1, 32'hC, 32'hB7, 16));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,  32'h0,          17));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h40, 32'hA500_0010, 18));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h44, 32'hA500_0011, 19));

    run_table(0, 20, 1'b0);

    // Top-of-memory wrap, then 32-bit PC rollover
    apply_reset();
    model_en = 1'b1;
    repeat (3) cycle(1, 0, 32'h0, -1);
    cycle(1, 1, 32'h0000_1FF8, 2046);
    cycle(1, 0, 32'h0, 2047);
    cycle(1, 0, 32'h0, 0);
    repeat (3) cycle(1, 0, 32'h0, -1);
    cycle(1, 1, 32'hFFFF_FFFC, 2047);
    repeat (4) cycle(1, 0, 32'h0, -1);

    // Reset during a pending redirect, then the startup sequence again
    mid_reset();
    model_en = 1'b0;
    run_table(0, 5, 1'b1);

    // Random traffic against the stream model
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    apply_reset();
    model_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) mid_reset();
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      cycle(rdy, rv, rpc, rv ? int'(rpc[AW+1:2]) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
